// File: rtl/rr_mux_arbiter16_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter16_pkg
//
// Shared definitions for the 16-way round-robin arbiter with its 32-bit data
// mux: requester count, data and select widths, the IDLE/BUSY state encoding,
// and the round-robin search used by the arbiter.
//
// Contents:
//   NUM_REQ, DATA_W, SEL_W, HOLD_W - structural widths
//   state_e                        - arbiter FSM state encoding
//   rr_pick_t                      - result of a round-robin search
//   rr_pick()                      - first set REQ bit at or after a start
//                                    index, wrapping from 15 to 0
// -----------------------------------------------------------------------------
package rr_mux_arbiter16_pkg;

  localparam int NUM_REQ = 16;
  localparam int DATA_W  = 32;
  localparam int SEL_W   = 4;
  // Hold counter width; it saturates at MAX_HOLD, which is at most 15.
  localparam int HOLD_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no grant outstanding
    ST_BUSY = 1'b1   // exactly one grant outstanding
  } state_e;

  typedef struct packed {
    logic             found;  // at least one request bit was set
    logic [SEL_W-1:0] idx;    // index of the winning requester
  } rr_pick_t;

  // Round-robin search: the winner is the first set bit of req reached when
  // walking upward from start and wrapping past NUM_REQ-1 back to 0.
  // The loop visits offsets from farthest to nearest, so the last match
  // written is the one closest to start. The 4-bit index addition wraps
  // naturally, which gives the modulo-16 walk for free.
  function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                       input logic [SEL_W-1:0]   start);
    rr_pick_t         res;
    logic [SEL_W-1:0] k;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = start + SEL_W'(i);
      if (req[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage : rr_mux_arbiter16_pkg

// File: rtl/rr_mux_arbiter16_mux32_16x1.sv
// -----------------------------------------------------------------------------
// MUX32_16x1
//
// Purely combinational 16:1 multiplexer of 32-bit words. The input bus is the
// flattened concatenation of the sixteen words, word k at bits
// [32k+31:32k].
//
// Ports:
//   d_i   [NUM_REQ*DATA_W-1:0]  flattened data inputs
//   sel_i [SEL_W-1:0]           word select
//   y_o   [DATA_W-1:0]          selected word
// -----------------------------------------------------------------------------
module MUX32_16x1
  import rr_mux_arbiter16_pkg::*;
(
  input  logic [NUM_REQ*DATA_W-1:0] d_i,
  input  logic [SEL_W-1:0]          sel_i,
  output logic [DATA_W-1:0]         y_o
);

  // Unpack the flat bus into lanes so the select is a plain array index.
  logic [DATA_W-1:0] lanes [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign lanes[k] = d_i[k*DATA_W +: DATA_W];
  end

  assign y_o = lanes[sel_i];

endmodule : MUX32_16x1

// File: rtl/rr_mux_arbiter16.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter16
//
// Round-robin arbiter for sixteen requesters that also steers the winner's
// 32-bit data word to the output. A grant is held while its requester keeps
// asking, but for at most MAX_HOLD consecutive cycles when somebody else is
// waiting; it is handed over immediately (no VALID gap) when the owner
// drops its request and others are pending.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles under contention, 1..15
//
// Ports:
//   CLK    clock, all state updates on the rising edge
//   RST    synchronous active-low reset
//   REQ    [15:0]   request bit per requester
//   D      [511:0]  flattened data inputs, word k = D[32k+31:32k]
//   GNT    [15:0]   registered one-hot grant, zero when idle
//   S      [3:0]    registered mux select = index of the granted requester
//   VALID           registered, high while a grant is active
//   Y      [31:0]   D word S while VALID, otherwise zero
// -----------------------------------------------------------------------------
module rr_mux_arbiter16
  import rr_mux_arbiter16_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*DATA_W-1:0] D,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [SEL_W-1:0]          S,
  output logic                      VALID,
  output logic [DATA_W-1:0]         Y
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q,   gnt_d;
  logic [SEL_W-1:0]    s_q,     s_d;
  logic                valid_q, valid_d;
  logic [SEL_W-1:0]    ptr_q,   ptr_d;   // round-robin search start
  logic [HOLD_W-1:0]   hold_q,  hold_d;  // cycles the current grant has lasted

  // ---------------------------------------------------------------------------
  // Decision terms
  // ---------------------------------------------------------------------------
  rr_pick_t pick;
  logic     owner_req;    // current owner is still requesting
  logic     others_req;   // someone other than the owner is requesting
  logic     hold_at_max;
  logic     new_grant;    // a fresh round-robin decision is taken this edge

  // ptr_q always points one past the last grant, so searching from it in
  // BUSY reaches every other requester before coming back to the owner.
  // That makes one search serve the idle start, the release handoff and
  // the forced rotation alike.
  assign pick        = rr_pick(REQ, ptr_q);
  assign owner_req   = REQ[s_q];
  assign others_req  = |(REQ & ~(NUM_REQ'(1) << s_q));
  assign hold_at_max = (hold_q == HOLD_MAX);

  always_comb begin
    new_grant = 1'b0;
    unique case (state_q)
      ST_IDLE: new_grant = pick.found;
      ST_BUSY: new_grant = pick.found &&
                           (!owner_req || (hold_at_max && others_req));
      default: new_grant = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: a grant exists exactly while some request is present.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick.found)  state_d = ST_BUSY;
      ST_BUSY: if (!pick.found) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_d   = gnt_q;
    s_d     = s_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    if (state_d == ST_IDLE) begin
      // Going or staying idle: drop the grant, keep S and the pointer.
      gnt_d   = '0;
      valid_d = 1'b0;
      hold_d  = '0;
    end else if (new_grant) begin
      gnt_d   = NUM_REQ'(1) << pick.idx;
      s_d     = pick.idx;
      valid_d = 1'b1;
      ptr_d   = pick.idx + SEL_W'(1);
      hold_d  = HOLD_W'(1);
    end else if (!hold_at_max) begin
      // Owner keeps the grant; count up and saturate at MAX_HOLD.
      hold_d  = hold_q + HOLD_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Data path
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mux_y;

  MUX32_16x1 u_mux (
    .d_i   (D),
    .sel_i (s_q),
    .y_o   (mux_y)
  );

  assign GNT   = gnt_q;
  assign S     = s_q;
  assign VALID = valid_q;
  // S is kept after release, so the mux output must be masked when idle.
  assign Y     = valid_q ? mux_y : '0;

endmodule : rr_mux_arbiter16

// File: tb/tb_rr_mux_arbiter16.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter16
//
// Directed scenarios followed by a randomized phase, all compared against a
// behavioural model of the arbiter kept in this file.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter16;

  localparam int MH = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [15:0]   REQ;
  logic [511:0]  D;
  logic [15:0]   GNT;
  logic [3:0]    S;
  logic          VALID;
  logic [31:0]   Y;

  rr_mux_arbiter16 #(.MAX_HOLD(MH)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .D     (D),
    .GNT   (GNT),
    .S     (S),
    .VALID (VALID),
    .Y     (Y)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [31:0] data [16];
  bit          m_valid;
  int          m_s;
  int          m_ptr;
  int          m_hold;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_d();
    for (int k = 0; k < 16; k++) D[k*32 +: 32] = data[k];
  endtask

  // First requesting index reached walking up from start, wrapping at 16.
  function automatic int rr_search(input logic [15:0] req, input int start);
    for (int off = 0; off < 16; off++) begin
      int k;
      k = (start + off) % 16;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_grant(input int k);
    m_valid = 1'b1;
    m_s     = k;
    m_ptr   = (k + 1) % 16;
    m_hold  = 1;
  endtask

  // Apply one rising edge's worth of rules to the model, using the inputs
  // currently presented to the DUT.
  task automatic model_edge();
    if (!RST) begin
      m_valid = 1'b0;
      m_s     = 0;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (REQ == 16'h0) begin
      m_valid = 1'b0;
      m_hold  = 0;
    end else if (!m_valid) begin
      model_grant(rr_search(REQ, m_ptr));
    end else begin
      logic [15:0] others;
      others = REQ;
      others[m_s] = 1'b0;
      if (!REQ[m_s] || (m_hold == MH && others != 16'h0))
        model_grant(rr_search(REQ, m_ptr));
      else if (m_hold < MH)
        m_hold++;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [15:0] exp_gnt;
    logic [31:0] exp_y;
    exp_gnt = m_valid ? (16'h1 << m_s) : 16'h0;
    exp_y   = m_valid ? data[m_s] : 32'h0;
    check({tag, ".gnt"},   32'(GNT),   32'(exp_gnt));
    check({tag, ".s"},     32'(S),     32'(m_s));
    check({tag, ".valid"}, 32'(VALID), 32'(m_valid));
    check({tag, ".y"},     Y,          exp_y);
  endtask

  // One clock: advance the model, let the edge happen, sample 1 time unit
  // later, and compare everything against the model.
  task automatic tick(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    compare_model(tag);
  endtask

  initial begin
    logic [3:0]  exp_rot [9];
    int          mode;

    for (int k = 0; k < 16; k++) data[k] = 32'(1431655700 + k);
    load_d();
    m_valid = 1'b0; m_s = 0; m_ptr = 0; m_hold = 0;

    // Reset held for two cycles with every requester asking.
    RST = 1'b0;
    REQ = 16'hFFFF;
    #1;
    tick("rst0");
    tick("rst1");
    check("rst.gnt",   32'(GNT),   32'h0);
    check("rst.s",     32'(S),     32'h0);
    check("rst.valid", 32'(VALID), 32'h0);
    check("rst.y",     Y,          32'h0);

    // Release: first decision starts from requester 0.
    RST = 1'b1;
    tick("rel");
    check("rel.gnt",   32'(GNT),   32'h0001);
    check("rel.s",     32'(S),     32'h0);
    check("rel.valid", 32'(VALID), 32'h1);

    // Rotation with wrap under MAX_HOLD=4: the release grant is the first of
    // four cycles on requester 0, then four on 15, then back to 0.
    REQ = 16'h8001;
    exp_rot = '{4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0};
    for (int i = 0; i < 9; i++) begin
      tick($sformatf("rot%0d", i));
      check($sformatf("rot%0d.s_lit", i), 32'(S), 32'(exp_rot[i]));
      check($sformatf("rot%0d.valid_lit", i), 32'(VALID), 32'h1);
    end

    // Single requester 5: owner 0 releases, handoff at the same edge, then
    // the grant is kept indefinitely.
    REQ = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      tick($sformatf("single%0d", i));
      check($sformatf("single%0d.gnt_lit", i), 32'(GNT), 32'h0020);
      check($sformatf("single%0d.y_lit", i),   Y,        32'd1431655705);
    end

    // Handoff 3 -> 4 with no VALID gap.
    REQ = 16'h0018;
    tick("ho_a");
    check("ho_a.s_lit", 32'(S), 32'd3);
    REQ = 16'h0010;
    tick("ho_b");
    check("ho_b.gnt_lit",   32'(GNT),   32'h0010);
    check("ho_b.s_lit",     32'(S),     32'd4);
    check("ho_b.valid_lit", 32'(VALID), 32'h1);

    // Idle: VALID drops, S keeps its last value, Y masked.
    REQ = 16'h0000;
    tick("idle");
    check("idle.valid_lit", 32'(VALID), 32'h0);
    check("idle.y_lit",     Y,          32'h0);
    check("idle.s_lit",     32'(S),     32'd4);
    tick("idle2");
    // Pointer is 5 now; requester 0 is found after wrapping.
    REQ = 16'h0001;
    tick("rereq");
    check("rereq.s_lit",   32'(S),   32'd0);
    check("rereq.gnt_lit", 32'(GNT), 32'h0001);

    // Mid-operation reset while requester 9 owns the grant.
    REQ = 16'h0200;
    tick("pre_mid");
    check("pre_mid.s_lit", 32'(S), 32'd9);
    RST = 1'b0;
    tick("mid_rst");
    check("mid_rst.gnt_lit",   32'(GNT),   32'h0);
    check("mid_rst.valid_lit", 32'(VALID), 32'h0);
    check("mid_rst.s_lit",     32'(S),     32'h0);
    RST = 1'b1;
    tick("mid_rel");
    check("mid_rel.s_lit", 32'(S), 32'd9);

    // Randomized phase: mix of idle, single, dense and held request patterns
    // with occasional resets and data refreshes.
    for (int i = 0; i < 600; i++) begin
      mode = int'($urandom_range(0, 5));
      case (mode)
        0:       REQ = 16'h0;
        1:       REQ = 16'h1 << $urandom_range(0, 15);
        2:       REQ = 16'($urandom);
        3:       REQ = 16'($urandom) & 16'($urandom);
        default: ;  // keep previous REQ so holds reach MAX_HOLD
      endcase
      RST = ($urandom_range(0, 59) != 0);
      if ((i % 17) == 0) begin
        for (int k = 0; k < 16; k++) data[k] = $urandom;
        load_d();
      end
      tick($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rr_mux_arbiter16

// File: doc/rr_mux_arbiter16.md
RR_MUX_ARBITER16 -- requirements
Module: rr_mux_arbiter16

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4: the maximum number of consecutive cycles a grant is held while other requests are pending; legal range 1..15.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port REQ, input, 16 bits: bit k is the access request from requester k.
REQ-005 SHALL have port D, input, 512 bits: the flattened mux data inputs, where input k = D[32k+31:32k].
REQ-006 SHALL have port GNT, output, 16 bits: one-hot grant, or all-zero when idle.
REQ-007 SHALL have port S, output, 4 bits: the select value driven to the mux; equals the index of the granted requester.
REQ-008 SHALL have port VALID, output, 1 bit: high while any grant is active.
REQ-009 SHALL have port Y, output, 32 bits: the selected data.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and BUSY (grant active).
REQ-011 SHALL register GNT, S and VALID, and SHALL hold GNT one-hot or zero at all times.
REQ-012 SHALL drive Y combinationally as input S of D when VALID=1, and as 32'h0 when VALID=0.
REQ-013 SHALL keep a 4-bit round-robin pointer PTR, and SHALL search REQ starting at PTR upward, wrapping from 15 to 0.
REQ-014 SHALL set PTR to (k+1) mod 16 on every new grant to requester k.
REQ-015 SHALL, in IDLE with REQ nonzero at edge n, show GNT, S and VALID=1 after edge n (one-cycle latency), move to BUSY, and set the hold count to 1.
REQ-016 SHALL, in IDLE with REQ=0, stay in IDLE and leave PTR unchanged.
REQ-017 SHALL, in BUSY with REQ[S]=0 and another request pending, grant the next requester in round-robin order at the same edge, with no VALID gap.
REQ-018 SHALL, in BUSY with REQ=0, go to IDLE at the next edge with GNT=0 and VALID=0, leaving S at its last value.
REQ-019 SHALL, in BUSY with REQ[S]=1, hold count = MAX_HOLD and another request pending, rotate to the next requester after S.
REQ-020 SHALL, in BUSY with REQ[S]=1 otherwise, keep the grant and increment the hold count, saturating at MAX_HOLD.
REQ-021 SHALL reset the hold count to 1 on every new grant.
REQ-022 SHALL never grant a requester whose REQ bit is 0 at the deciding edge.
REQ-023 SHALL treat simultaneous release and new requests as one round-robin decision evaluated on the current REQ.

Reset
REQ-024 SHALL, with RST=0 at a rising edge, set state IDLE, GNT=0, S=0, VALID=0, PTR=0 and hold count 0, so that Y=0.
REQ-025 SHALL give reset priority over any in-progress grant.
REQ-026 SHALL make the first decision after RST returns high at the following edge, starting the search from PTR=0.

Structure
REQ-027 SHALL take NUM_REQ=16, DATA_W=32, SEL_W=4 and the IDLE/BUSY state encodings from the shared project definitions package.
REQ-028 SHALL contain exactly one sub-module, MUX32_16x1, instanced for the data path; it is fed from D and S, and its output is gated by VALID.
REQ-029 SHALL implement round-robin selection as a single combinational function of REQ and the search start.

Verification
REQ-030 SHALL cover reset: RST=0 for 2 cycles with REQ=16'hFFFF -> GNT=0, S=0, VALID=0, Y=0; after RST=1, the next edge gives GNT=16'h0001, S=0, VALID=1.
REQ-031 SHALL cover a single requester: REQ=16'h0020 held 10 cycles, MAX_HOLD=4, input k of D = 1431655700+k -> GNT=16'h0020 throughout, S=5, Y=1431655705.
REQ-032 SHALL cover rotation with wrap: REQ=16'h8001 held, MAX_HOLD=4 -> S=0 for 4 cycles, then S=15 for 4 cycles, then S=0 again; VALID stays 1.
REQ-033 SHALL cover handoff: granted S=3 and REQ changes 16'h0018 -> 16'h0010 -> the next edge gives GNT=16'h0010, S=4, and no VALID gap.
REQ-034 SHALL cover idle and re-request: REQ drops to 0 -> the next edge gives VALID=0, Y=0; then REQ=16'h0001 with PTR=5 -> S=0 after a wrap search.
REQ-035 SHALL cover mid-operation reset: RST=0 while S=9 is in BUSY -> at that edge GNT=0, VALID=0, S=0; after release with REQ=16'h0200 -> S=9.
